// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the iterative multiply/divide unit
package muldiv_pkg;

  localparam int MDU_WIDTH = 64;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

  typedef enum logic [1:0] {OP_MUL, OP_UDIV, OP_SDIV, OP_RSVD} mdu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mdu_state_t;

  // The reserved encoding falls through to multiply.
  function automatic logic mdu_is_div(input mdu_op_t op);
    return (op == OP_UDIV) || (op == OP_SDIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one radix-2 iteration: shift-add multiply step or restoring divide step
module mdu_step #(
  parameter int WIDTH = 64
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_opnd,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_qbit
);

  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;

  // The remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow.
  assign w_trial = {i_acc, i_bit};
  assign w_diff  = w_trial - {1'b0, i_opnd};

  always_comb begin
    o_acc  = i_acc;
    o_qbit = 1'b0;
    if (i_div) begin
      if (!w_diff[WIDTH]) begin
        o_acc  = w_diff[WIDTH-1:0];
        o_qbit = 1'b1;
      end else begin
        o_acc  = w_trial[WIDTH-1:0];
      end
    end else if (i_bit) begin
      o_acc = i_acc + i_opnd;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit: FSM, counter, operand registers, sign fix-up
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_div;
  logic             r_neg;
  logic [WIDTH-1:0] r_result;

  mdu_op_t          w_op;
  logic             w_div;
  logic             w_sdiv;
  logic             w_div0;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_qbit;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_final;

  assign w_op    = mdu_op_t'(op);
  assign w_div   = mdu_is_div(w_op);
  assign w_sdiv  = (w_op == OP_SDIV);
  assign w_div0  = w_div && (opB == '0);
  // Magnitudes are taken as unsigned, so the most-negative value maps onto itself correctly.
  assign w_abs_a = (w_sdiv && opA[WIDTH-1]) ? -opA : opA;
  assign w_abs_b = (w_sdiv && opB[WIDTH-1]) ? -opB : opB;

  // Divide: r_a holds the dividend shifting out at the top and the quotient shifting in at the bottom.
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_div),
    .i_acc  (r_acc),
    .i_opnd (r_div ? r_b : r_a),
    .i_bit  (r_div ? r_a[WIDTH-1] : r_b[0]),
    .o_acc  (w_acc_nxt),
    .o_qbit (w_qbit)
  );

  assign w_quot  = {r_a[WIDTH-2:0], w_qbit};
  assign w_final = r_div ? (r_neg ? -w_quot : w_quot) : w_acc_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_div    <= 1'b0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_div <= w_div;
            r_neg <= w_sdiv && (opA[WIDTH-1] ^ opB[WIDTH-1]);
            r_a   <= w_div ? w_abs_a : opA;
            r_b   <= w_div ? w_abs_b : opB;
            r_acc <= '0;
            r_cnt <= '0;
            if (w_div0) begin
              r_state  <= S_DONE;
              r_result <= '0;
            end else begin
              r_state  <= S_RUN;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            if (r_div) begin
              r_a <= w_quot;
            end else begin
              r_a <= r_a << 1;
              r_b <= r_b >> 1;
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_state  <= S_DONE;
              r_result <= w_final;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule
